// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Frame layout shared by the spi_tx transmitter and the spi
//             receiver: frame width, field LSB positions and FSM state codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int FRAME_BITS = 60;

    // Field LSB positions inside the 60-bit frame (bit 59 is sent first)
    localparam int AI_LSB  = 52;
    localparam int DI_LSB  = 44;
    localparam int S_LSB   = 36;
    localparam int RI_LSB  = 28;
    localparam int OSC_LSB = 16;
    localparam int FA_LSB  = 8;
    localparam int FB_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_tx_if.sv
// ============================================================================
//  Module   : spi_tx_if
//  Purpose  : Request handshake, synth parameter fields and serial outputs
//             of the spi_tx transmitter.
//  Modports : master - host side (drives valid and parameters)
//             slave  - spi_tx    (drives ready, nss, mosi, done)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_tx_if;
    logic        valid;
    logic        ready;
    logic [7:0]  adsr_ai;
    logic [7:0]  adsr_di;
    logic [7:0]  adsr_s;
    logic [7:0]  adsr_ri;
    logic [11:0] osc_count;
    logic [7:0]  filter_a;
    logic [7:0]  filter_b;
    logic        nss;
    logic        mosi;
    logic        done;

    modport master (
        output valid, adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b,
        input  ready, nss, mosi, done
    );

    modport slave (
        input  valid, adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b,
        output ready, nss, mosi, done
    );
endinterface

`default_nettype wire

// File: rtl/spi_frame_pack.sv
// ============================================================================
//  Module   : spi_frame_pack
//  Purpose  : Combinational packing of the seven synth parameter fields into
//             the 60-bit serial frame.
//  Ports    : ai_i, di_i, s_i, ri_i, fa_i, fb_i (8b), osc_i (12b) in;
//             frame_o (60b) out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_pack
    import spi_pkg::*;
(
    input  logic [7:0]            ai_i,
    input  logic [7:0]            di_i,
    input  logic [7:0]            s_i,
    input  logic [7:0]            ri_i,
    input  logic [11:0]           osc_i,
    input  logic [7:0]            fa_i,
    input  logic [7:0]            fb_i,
    output logic [FRAME_BITS-1:0] frame_o
);

    always_comb begin
        frame_o                  = '0;
        frame_o[AI_LSB  +: 8]    = ai_i;
        frame_o[DI_LSB  +: 8]    = di_i;
        frame_o[S_LSB   +: 8]    = s_i;
        frame_o[RI_LSB  +: 8]    = ri_i;
        frame_o[OSC_LSB +: 12]   = osc_i;
        frame_o[FA_LSB  +: 8]    = fa_i;
        frame_o[FB_LSB  +: 8]    = fb_i;
    end

endmodule

`default_nettype wire

// File: rtl/spi_tx.sv
// ============================================================================
//  Module   : spi_tx
//  Purpose  : Serial frame transmitter for the synth parameter link. Latches
//             the parameter set on acceptance, shifts the 60-bit frame out
//             MSB first one bit per clk with nss low, then idles GAP_CYCLES
//             cycles with nss high before accepting the next request.
//  Ports    : clk, rst (sync, active high); bus (spi_tx_if.slave).
//  Params   : GAP_CYCLES (>=1) idle cycles after each frame.
//  Options  : SPI_TX_AUTOSEND_EN - resend automatically whenever the packed
//             inputs differ from the last transmitted frame.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx
    import spi_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    spi_tx_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_GAP   = GAP;

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

    logic [1:0]            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]            cnt_q,   cnt_d;
    logic [GAP_W-1:0]      gap_q,   gap_d;
    logic                  nss_q,   nss_d;
    logic                  mosi_q,  mosi_d;
    logic                  ready_q, ready_d;
    logic                  done_q,  done_d;
    logic [FRAME_BITS-1:0] frame;
    logic                  start;

    spi_frame_pack u_pack (
        .ai_i    (bus.adsr_ai),
        .di_i    (bus.adsr_di),
        .s_i     (bus.adsr_s),
        .ri_i    (bus.adsr_ri),
        .osc_i   (bus.osc_count),
        .fa_i    (bus.filter_a),
        .fb_i    (bus.filter_b),
        .frame_o (frame)
    );

`ifdef SPI_TX_AUTOSEND_EN
    logic [FRAME_BITS-1:0] shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    assign start = pending_q || bus.valid;
`else
    assign start = bus.valid;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        nss_d   = nss_q;
        mosi_d  = mosi_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef SPI_TX_AUTOSEND_EN
        shadow_d  = shadow_q;
        pending_d = pending_q || (frame != shadow_q);
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // shreg[59] always mirrors the bit currently on mosi
                    state_d = S_SHIFT;
                    shreg_d = frame;
                    cnt_d   = '0;
                    nss_d   = 1'b0;
                    mosi_d  = frame[FRAME_BITS-1];
                    ready_d = 1'b0;
`ifdef SPI_TX_AUTOSEND_EN
                    shadow_d  = frame;
                    pending_d = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    nss_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    shreg_d = shreg_q << 1;
                    mosi_d  = shreg_q[FRAME_BITS-2];
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                nss_d   = 1'b1;
                mosi_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            nss_q   <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            nss_q   <= nss_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_TX_AUTOSEND_EN
    // Shadow resets to 0, so any nonzero input set after reset sends once
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end
`endif

    assign bus.ready = ready_q;
    assign bus.nss   = nss_q;
    assign bus.mosi  = mosi_q;
    assign bus.done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx.sv
// ============================================================================
//  Module   : tb_spi_tx
//  Purpose  : Self-checking bench for spi_tx. A monitor deserializes every
//             nss-low window and compares it with the frame queued when the
//             request was driven. Build with SPI_TX_AUTOSEND_EN to exercise
//             the autosend option instead of the valid-driven sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_tx;

    localparam int GAP_CYC = 2;
    localparam int PERIOD  = 61 + GAP_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_tx_if bus ();

    spi_tx #(.GAP_CYCLES(GAP_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ai, di, s, ri;
        logic [11:0] osc;
        logic [7:0]  fa, fb;
        logic [59:0] exp_frame;
    } vec_t;

    vec_t        vecs [6];
    logic [59:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: deserialize frames, check length, data, done and idle mosi
    // ------------------------------------------------------------------
    logic        prev_nss  = 1'b1;
    logic        abort_exp = 1'b0;
    logic        exp_done;
    logic [59:0] cap = '0;
    logic [59:0] exp_f;
    int          nbits = 0, falls = 0, last_fall = 0, prev_fall = 0;
    int          hi_run = 0, last_gap_run = 0, frames_done = 0, aborts = 0;

    always @(negedge clk) begin
        exp_done = (!prev_nss && bus.nss === 1'b1 && !abort_exp);
        if (bus.nss === 1'b0) begin
            if (prev_nss) begin
                falls++;
                prev_fall    = last_fall;
                last_fall    = cyc;
                last_gap_run = hi_run;
                nbits        = 0;
                cap          = '0;
            end
            cap = {cap[58:0], bus.mosi};
            nbits++;
        end else begin
            if (!prev_nss) begin
                if (abort_exp) begin
                    aborts++;
                end else begin
                    checks++;
                    if (nbits != 60) begin
                        errors++;
                        $display("FAIL frame_len: got %0d bits, required 60", nbits);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got %h, none expected", cap);
                    end else begin
                        exp_f = exp_q.pop_front();
                        if (cap !== exp_f) begin
                            errors++;
                            $display("FAIL frame_data: got %h, required %h", cap, exp_f);
                        end
                    end
                    frames_done++;
                end
            end
            hi_run = prev_nss ? hi_run + 1 : 1;
            checks++;
            if (bus.mosi !== 1'b0) begin
                errors++;
                $display("FAIL idle_mosi: got %b, required 0", bus.mosi);
            end
        end
        if (exp_done || bus.done !== 1'b0) begin
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL done_pulse: got %b, required %b at cycle %0d", bus.done, exp_done, cyc);
            end
        end
        prev_nss = bus.nss;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.adsr_ai   = v.ai;
        bus.adsr_di   = v.di;
        bus.adsr_s    = v.s;
        bus.adsr_ri   = v.ri;
        bus.osc_count = v.osc;
        bus.filter_a  = v.fa;
        bus.filter_b  = v.fb;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (bus.ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles", bus.ready, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.ready !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d frames outstanding, ready=%b", exp_q.size(), bus.ready);
        end
    endtask

    task automatic send(input vec_t v);
        wait_ready(300);
        drive(v);
        bus.valid = 1'b1;
        exp_q.push_back(v.exp_frame);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int f0, fd0, acc_cyc, n;
        vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 12'h9AB, 8'hCD, 8'hEF, 60'h123456789ABCDEF};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 8'h00, 8'h00, 60'h000000000000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 12'hFFF, 8'hFF, 8'hFF, 60'hFFFFFFFFFFFFFFF};
        vecs[3] = '{8'h80, 8'h00, 8'h00, 8'h00, 12'h000, 8'h00, 8'h00, 60'h800000000000000};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 12'h001, 8'h00, 8'h01, 60'h000000000010001};
        vecs[5] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 12'hF0F, 8'h01, 8'h80, 60'hA55AC33CF0F0180};

        bus.valid = 1'b0;
        drive(vecs[1]);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_nss",   64'(bus.nss),   64'd1);
        chk("reset_mosi",  64'(bus.mosi),  64'd0);
        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_done",  64'(bus.done),  64'd0);

`ifdef SPI_TX_AUTOSEND_EN
        // Zero inputs match the cleared shadow: nothing may be sent
        repeat (100) @(posedge clk);
        #1;
        chk("auto_idle_falls", 64'(falls), 64'd0);
        // Nonzero inputs with valid low auto-send once
        exp_q.push_back(vecs[0].exp_frame);
        drive(vecs[0]);
        wait_idle(300);
        // filter_b change alone triggers exactly one frame ending in 0x01
        f0 = falls;
        exp_q.push_back(60'h123456789ABCD01);
        bus.filter_b = 8'h01;
        wait_idle(300);
        chk("auto_one_frame", 64'(falls), 64'(f0 + 1));
        f0 = falls;
        repeat (200) @(posedge clk);
        #1;
        chk("auto_steady", 64'(falls), 64'(f0));
`else
        // Single frame with first-bit latency check
        send(vecs[0]);
        acc_cyc = cyc;
        @(negedge clk);
        #1;
        chk("first_nss_low",  64'(bus.nss),   64'd0);
        chk("first_mosi_b59", 64'(bus.mosi),  64'(vecs[0].exp_frame[59]));
        chk("first_latency",  64'(last_fall), 64'(acc_cyc));
        chk("busy_ready",     64'(bus.ready), 64'd0);
        wait_idle(300);
        chk("frames_after_first", 64'(frames_done), 64'd1);

        // Table of patterns, sent at the maximum rate the handshake allows
        for (int i = 1; i < 6; i++) send(vecs[i]);
        wait_idle(400);
        chk("table_period", 64'(last_fall - prev_fall), 64'(PERIOD));
        chk("table_gap",    64'(last_gap_run),          64'(GAP_CYC + 1));

        // valid held high continuously
        f0 = falls;
        drive(vecs[5]);
        exp_q.push_back(vecs[5].exp_frame);
        exp_q.push_back(vecs[5].exp_frame);
        bus.valid = 1'b1;
        n = 0;
        while (falls < f0 + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        bus.valid = 1'b0;
        wait_idle(300);
        chk("held_frames", 64'(falls),                 64'(f0 + 2));
        chk("held_period", 64'(last_fall - prev_fall), 64'(PERIOD));
        chk("held_gap",    64'(last_gap_run),          64'(GAP_CYC + 1));

        // Inputs change and valid pulses at bit 30: frame in flight unaltered
        f0 = falls;
        send(vecs[0]);
        repeat (29) @(posedge clk);
        #1;
        drive(vecs[2]);
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        wait_idle(300);
        repeat (80) @(posedge clk);
        #1;
        chk("midframe_no_second", 64'(falls), 64'(f0 + 1));

        // Reset at bit 20: truncated, no done, then a clean frame
        fd0 = frames_done;
        send(vecs[5]);
        repeat (20) @(posedge clk);
        #1;
        abort_exp = 1'b1;
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_nss",   64'(bus.nss),   64'd1);
        chk("abort_mosi",  64'(bus.mosi),  64'd0);
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_done",  64'(bus.done),  64'd0);
        @(negedge clk);
        #1;
        abort_exp = 1'b0;
        chk("abort_seen", 64'(aborts), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        send(vecs[0]);
        wait_idle(300);
        chk("post_abort_frame", 64'(frames_done), 64'(fd0 + 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
